// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the reaction-game round sequencer.
//   game_state_t : FSM state encoding (IDLE=0, DELAY=1, CUE=2, RESULT=3, DONE=4)
//   PTS_*        : points awarded per reaction class
//   LFSR_SEED    : reset value of the arming-delay LFSR
//   lfsr8_next   : one step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR
// ---------------------------------------------------------------------------
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY  = 3'd1,
    ST_CUE    = 3'd2,
    ST_RESULT = 3'd3,
    ST_DONE   = 3'd4
  } game_state_t;

  localparam logic [1:0] PTS_FAST = 2'd3;
  localparam logic [1:0] PTS_MED  = 2'd2;
  localparam logic [1:0] PTS_SLOW = 2'd1;
  localparam logic [1:0] PTS_MISS = 2'd0;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Shift left; feedback from taps 8,6,5,4. Maximal length, so a nonzero
  // seed never reaches the all-zero lockup state.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/game_lfsr8.sv
// ---------------------------------------------------------------------------
// game_lfsr8
// Free-running 8-bit Fibonacci LFSR, advances every clock.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (loads SEED)
//   lfsr_o : current LFSR value
// ---------------------------------------------------------------------------
module game_lfsr8
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] lfsr_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = lfsr8_next(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/game_round_ctrl.sv
// ---------------------------------------------------------------------------
// game_round_ctrl
// Round sequencer for the reaction game: random arming delay, cue, reaction
// timing, scoring, and round/game bookkeeping.
//   clk, rst_n     : clock, asynchronous active-low reset
//   tick_i         : one-cycle 1 ms enable
//   start_i        : start pulse (honoured in IDLE and DONE only)
//   btn_i          : player press pulse
//   state_o        : FSM state encoding
//   cue_o          : cue LED, high only in CUE
//   score_o        : accumulated, saturating score
//   round_o        : completed rounds
//   react_ms_o     : last reaction time in ms (TIMEOUT_MS on miss/false start)
//   false_start_o  : one-cycle pulse on a press during DELAY
//   done_o         : high in DONE
//   hiscore_o      : best game score, only with GAME_HISCORE_EN defined
// Build option: GAME_HISCORE_EN adds the high-score register and port.
// ---------------------------------------------------------------------------
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int ROUNDS       = 8,
  parameter int MIN_DELAY_MS = 200,
  parameter int TIMEOUT_MS   = 500,
  parameter int FAST_MS      = 100,
  parameter int RESULT_MS    = 300,
  parameter int REACT_W      = 10,
  parameter int SCORE_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_i,
  input  logic               start_i,
  input  logic               btn_i,
  output logic [2:0]         state_o,
  output logic               cue_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [3:0]         round_o,
  output logic [REACT_W-1:0] react_ms_o,
  output logic               false_start_o,
  output logic               done_o
`ifdef GAME_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore_o
`endif
);

  localparam logic [REACT_W-1:0] ONE_R     = REACT_W'(1);
  localparam logic [REACT_W-1:0] MIN_C     = REACT_W'(MIN_DELAY_MS);
  localparam logic [REACT_W-1:0] TIMEOUT_C = REACT_W'(TIMEOUT_MS);
  localparam logic [REACT_W-1:0] FAST_C    = REACT_W'(FAST_MS);
  localparam logic [REACT_W-1:0] HALF_C    = REACT_W'(TIMEOUT_MS / 2);
  // RESULT reuses the delay counter; loading N-1 and leaving on the tick
  // that finds it at zero gives exactly RESULT_MS ticks.
  localparam logic [REACT_W-1:0] RES_LD_C  = REACT_W'(RESULT_MS - 1);
  localparam logic [3:0]         ROUNDS_C  = 4'(ROUNDS);

  game_state_t        state_q, state_d;
  logic [REACT_W-1:0] dly_q, dly_d;      // arming delay / RESULT dwell
  logic [REACT_W-1:0] rct_q, rct_d;      // reaction counter in CUE
  logic [REACT_W-1:0] react_q, react_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [3:0]         round_q, round_d;
  logic               fs_q, fs_d;
  logic               cue_q, cue_d;
  logic               done_q, done_d;

  logic [7:0]         lfsr;
  logic [REACT_W-1:0] fresh_dly;
  logic               enter_res;
  logic [1:0]         pts;
  logic [SCORE_W:0]   score_sum;

  game_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .lfsr_o (lfsr)
  );

  assign fresh_dly = MIN_C + REACT_W'(lfsr);

  function automatic logic [1:0] pts_for(input logic [REACT_W-1:0] r);
    if (r < FAST_C)      return PTS_FAST;
    else if (r < HALF_C) return PTS_MED;
    return PTS_SLOW;
  endfunction

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    rct_d     = rct_q;
    react_d   = react_q;
    score_d   = score_q;
    round_d   = round_q;
    fs_d      = 1'b0;
    enter_res = 1'b0;
    pts       = PTS_MISS;

    unique case (state_q)
      ST_IDLE: begin
        score_d = '0;
        round_d = '0;
        if (start_i) begin
          state_d = ST_DELAY;
          dly_d   = fresh_dly;
        end
      end
      ST_DELAY: begin
        // A press beats a same-cycle tick.
        if (btn_i) begin
          fs_d      = 1'b1;
          react_d   = TIMEOUT_C;
          enter_res = 1'b1;
        end else if (tick_i) begin
          if (dly_q == '0) begin
            state_d = ST_CUE;
            rct_d   = '0;
          end else begin
            dly_d = dly_q - ONE_R;
          end
        end
      end
      ST_CUE: begin
        // Report the pre-increment count; a press in the timeout cycle wins.
        if (btn_i) begin
          react_d   = rct_q;
          pts       = pts_for(rct_q);
          enter_res = 1'b1;
        end else if (tick_i) begin
          rct_d = rct_q + ONE_R;
          if (rct_q == TIMEOUT_C - ONE_R) begin
            react_d   = TIMEOUT_C;
            enter_res = 1'b1;
          end
        end
      end
      ST_RESULT: begin
        if (tick_i) begin
          if (dly_q == '0) begin
            round_d = round_q + 4'd1;
            if ((round_q + 4'd1) == ROUNDS_C) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DELAY;
              dly_d   = fresh_dly;
            end
          end else begin
            dly_d = dly_q - ONE_R;
          end
        end
      end
      ST_DONE: begin
        if (start_i) begin
          state_d = ST_DELAY;
          dly_d   = fresh_dly;
          score_d = '0;
          round_d = '0;
          react_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_res) begin
      state_d = ST_RESULT;
      dly_d   = RES_LD_C;
      score_d = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
    end

    cue_d  = (state_d == ST_CUE);
    done_d = (state_d == ST_DONE);
  end

  assign score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, pts};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      rct_q   <= '0;
      react_q <= '0;
      score_q <= '0;
      round_q <= '0;
      fs_q    <= 1'b0;
      cue_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rct_q   <= rct_d;
      react_q <= react_d;
      score_q <= score_d;
      round_q <= round_d;
      fs_q    <= fs_d;
      cue_q   <= cue_d;
      done_q  <= done_d;
    end
  end

`ifdef GAME_HISCORE_EN
  logic [SCORE_W-1:0] hi_q, hi_d;

  // Score is final by the time RESULT exits, so compare on DONE entry.
  always_comb begin
    hi_d = hi_q;
    if (state_d == ST_DONE && state_q != ST_DONE && score_q > hi_q)
      hi_d = score_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hi_q <= '0;
    else        hi_q <= hi_d;
  end

  assign hiscore_o = hi_q;
`endif

  assign state_o       = state_q;
  assign cue_o         = cue_q;
  assign score_o       = score_q;
  assign round_o       = round_q;
  assign react_ms_o    = react_q;
  assign false_start_o = fs_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_round_ctrl
// Random reaction-game stimulus with a scoreboard: the driver pushes the
// expected round outcome, a negedge monitor pops it on every RESULT entry and
// also checks arming delay length, RESULT dwell, round/score bookkeeping and
// the DONE summary. A second instance with SCORE_W=4 checks saturation.
// ---------------------------------------------------------------------------
module tb_game_round_ctrl;

  localparam int ROUNDS     = 8;
  localparam int MIN_DLY    = 200;
  localparam int TIMEOUT_MS = 500;
  localparam int FAST_MS    = 100;
  localparam int RESULT_MS  = 300;
  localparam int S_IDLE = 0, S_DELAY = 1, S_CUE = 2, S_RESULT = 3, S_DONE = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_i = 1'b0, start_i = 1'b0, btn_i = 1'b0;
  logic [2:0] state_o, sat_state;
  logic       cue_o, fs_o, done_o, sat_cue, sat_fs, sat_done;
  logic [7:0] score_o;
  logic [3:0] round_o, sat_round;
  logic [9:0] react_o, sat_react;
  logic [3:0] sat_score;
`ifdef GAME_HISCORE_EN
  logic [7:0] hiscore_o;
  logic [3:0] sat_hiscore;
`endif

  always #5 clk = ~clk;

  game_round_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_i(start_i), .btn_i(btn_i),
    .state_o(state_o), .cue_o(cue_o), .score_o(score_o), .round_o(round_o),
    .react_ms_o(react_o), .false_start_o(fs_o), .done_o(done_o)
`ifdef GAME_HISCORE_EN
    , .hiscore_o(hiscore_o)
`endif
  );

  game_round_ctrl #(.SCORE_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .tick_i(tick_i), .start_i(start_i), .btn_i(btn_i),
    .state_o(sat_state), .cue_o(sat_cue), .score_o(sat_score), .round_o(sat_round),
    .react_ms_o(sat_react), .false_start_o(sat_fs), .done_o(sat_done)
`ifdef GAME_HISCORE_EN
    , .hiscore_o(sat_hiscore)
`endif
  );

  // Reference LFSR, stepping alongside the design from the same seed.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct { int react; int pts; int fs; } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  bit abort  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pts_of(input int ms);
    if (ms < FAST_MS) return 3;
    if (ms < TIMEOUT_MS / 2) return 2;
    return 1;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ------------------------------------------------------------------ monitor
  int pst = S_IDLE, pt = 0, pb = 0, plfsr = 0;
  int dly_ticks = 0, exp_dly = 0, res_ticks = 0;
  int m_score = 0, m_sat = 0, m_round = 0, m_hi = 0;
  bit fs_chk = 1'b0;

  always @(negedge clk) begin
    int st;
    exp_t e;
    if (!rst_n) begin
      pst = S_IDLE; pt = 0; pb = 0; fs_chk = 1'b0;
      m_score = 0; m_sat = 0; m_round = 0; m_hi = 0;
    end else begin
      st = int'(state_o);
      if (fs_chk) begin
        chk("false_start_width", int'(fs_o), 0);
        fs_chk = 1'b0;
      end
      if (pst == S_DELAY && pt != 0 && pb == 0) dly_ticks++;
      if (pst == S_RESULT && pt != 0) res_ticks++;

      if (st == S_DELAY && pst != S_DELAY) begin
        if (pst == S_IDLE || pst == S_DONE) begin
          chk("start_score_clr", int'(score_o), 0);
          chk("start_round_clr", int'(round_o), 0);
          chk("start_react_clr", int'(react_o), 0);
          m_score = 0; m_sat = 0; m_round = 0;
        end
        exp_dly   = MIN_DLY + plfsr + 1;
        dly_ticks = 0;
      end

      if (st == S_CUE && pst != S_CUE) begin
        chk("delay_ticks", dly_ticks, exp_dly);
        chk("cue_high", int'(cue_o), 1);
      end

      if (st == S_RESULT && pst != S_RESULT) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          m_score = min_i(m_score + e.pts, 255);
          m_sat   = min_i(m_sat + e.pts, 15);
          chk("react_ms", int'(react_o), e.react);
          chk("score", int'(score_o), m_score);
          chk("score_sat4", int'(sat_score), m_sat);
          chk("false_start", int'(fs_o), e.fs);
          chk("cue_low_in_result", int'(cue_o), 0);
        end
        res_ticks = 0;
        fs_chk    = 1'b1;
      end

      if (pst == S_RESULT && st != S_RESULT) begin
        chk("result_ticks", res_ticks, RESULT_MS);
        chk("round_inc", int'(round_o), m_round + 1);
        m_round++;
        chk("exit_state", st, (m_round == ROUNDS) ? S_DONE : S_DELAY);
        if (st == S_DONE) begin
          chk("done_flag", int'(done_o), 1);
          chk("done_score", int'(score_o), m_score);
`ifdef GAME_HISCORE_EN
          if (m_score > m_hi) m_hi = m_score;
          chk("hiscore", int'(hiscore_o), m_hi);
`endif
        end
      end

      pst = st; pt = int'(tick_i); pb = int'(btn_i); plfsr = int'(m_lfsr);
    end
  end

  // ------------------------------------------------------------------ driver
  function automatic bit rnd_tick();
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic step(input bit t, input bit b, input bit s);
    tick_i = t; btn_i = b; start_i = s;
    @(posedge clk); #1;
    tick_i = 1'b0; btn_i = 1'b0; start_i = 1'b0;
  endtask

  task automatic wait_state(input int s, input int lim, input string nm);
    int n = 0;
    if (abort) return;
    while (int'(state_o) != s) begin
      if (n == lim) begin
        checks++; errors++;
        $display("FAIL timeout_%s state=%0d expected=%0d", nm, state_o, s);
        abort = 1'b1;
        return;
      end
      step(rnd_tick(), 1'b0, 1'b0);
      n++;
    end
  endtask

  // fixed=1: every press 10 ticks after the cue.
  task automatic play_game(input bit fixed);
    int sel, n, cnt, k;
    bit t;
    exp_t e;
    if (abort) return;
    step(rnd_tick(), 1'b0, 1'b1);
    for (int r = 0; r < ROUNDS; r++) begin
      wait_state(S_DELAY, 3000, "delay");
      if (abort) return;
      sel = fixed ? 3 : int'($urandom_range(0, 11));
      if (sel == 0) begin
        k = int'($urandom_range(0, 40));
        repeat (k) step(rnd_tick(), 1'b0, 1'b0);
        e = '{TIMEOUT_MS, 0, 1};
        sb.push_back(e);
        step(rnd_tick(), 1'b1, 1'b0);
        continue;
      end
      wait_state(S_CUE, 3000, "cue");
      if (abort) return;
      cnt = 0;
      if (sel == 1) begin
        e = '{TIMEOUT_MS, 0, 0};
        sb.push_back(e);
        while (cnt < TIMEOUT_MS) begin
          t = rnd_tick();
          step(t, 1'b0, 1'b0);
          if (t) cnt++;
        end
        continue;
      end
      case (sel)
        2:       n = TIMEOUT_MS - 1;
        3:       n = fixed ? 10 : int'($urandom_range(0, 99));
        4, 5:    n = int'($urandom_range(0, 99));
        6, 7:    n = int'($urandom_range(100, 249));
        9:       begin
                   k = int'($urandom_range(0, 4));
                   n = (k == 0) ? 99 : (k == 1) ? 100 : (k == 2) ? 249 : (k == 3) ? 250 : 0;
                 end
        default: n = int'($urandom_range(250, 498));
      endcase
      e = '{n, pts_of(n), 0};
      sb.push_back(e);
      while (1) begin
        if (cnt == n) begin
          // Timeout-cycle press rides on a tick to exercise the tie.
          step((n == TIMEOUT_MS - 1) ? 1'b1 : rnd_tick(), 1'b1, 1'b0);
          break;
        end
        t = rnd_tick();
        step(t, 1'b0, 1'b0);
        if (t) cnt++;
      end
    end
    wait_state(S_DONE, 3000, "done");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_state", int'(state_o), S_IDLE);
    chk("rst_cue", int'(cue_o), 0);
    chk("rst_score", int'(score_o), 0);
    chk("rst_round", int'(round_o), 0);
    chk("rst_react", int'(react_o), 0);
    chk("rst_fs", int'(fs_o), 0);
    chk("rst_done", int'(done_o), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) step(rnd_tick(), 1'b1, 1'b0);   // presses in IDLE do nothing
    chk("idle_holds", int'(state_o), S_IDLE);

    play_game(1'b0);
    play_game(1'b1);
    if (!abort) begin
      chk("full_game_score", int'(score_o), 24);
      chk("full_game_sat", int'(sat_score), 15);
      chk("full_game_round", int'(round_o), 8);
    end

    if (!abort) begin
      step(rnd_tick(), 1'b0, 1'b1);
      wait_state(S_CUE, 3000, "cue_rst");
    end
    if (!abort) begin
      #3 rst_n = 1'b0;
      #1;
      chk("arst_state", int'(state_o), S_IDLE);
      chk("arst_cue", int'(cue_o), 0);
      chk("arst_score", int'(score_o), 0);
      chk("arst_round", int'(round_o), 0);
      chk("arst_react", int'(react_o), 0);
      chk("arst_done", int'(done_o), 0);
`ifdef GAME_HISCORE_EN
      chk("arst_hiscore", int'(hiscore_o), 0);
`endif
    end
    sb.delete();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
